// File: rtl/bsg_reset_seq_pkg.sv
// bsg_reset_seq_pkg: shared state encoding and sizing helper for the reset release sequencer
package bsg_reset_seq_pkg;

    typedef enum logic [1:0] {eWait, eAck, eDone, eError} state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bsg_reset_seq_counter.sv
// bsg_reset_seq_counter: wrapping up-counter with synchronous clear and all-ones terminal flag
module bsg_reset_seq_counter #(
    parameter int width_p = 4
) (
    input  logic clk_i,
    input  logic clear_i,
    input  logic en_i,
    output logic tc_o
);

    logic [width_p-1:0] count;

    always_ff @(posedge clk_i)
        if (clear_i) count <= '0;
        else if (en_i) count <= count + 1'b1;

    assign tc_o = &count;

endmodule

// File: rtl/bsg_reset_release_sequencer.sv
// bsg_reset_release_sequencer: releases downstream stage resets one at a time, each after a settle wait and gated by its acknowledge
module bsg_reset_release_sequencer
    import bsg_reset_seq_pkg::*;
#(
    parameter int els_p = 3,
    parameter int lg_wait_cycles_p = 4,
    parameter int lg_ack_timeout_p = 3,
    localparam int idx_w = idx_width(els_p)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic [els_p-1:0] stage_ack_i,
    output logic [els_p-1:0] stage_reset_o,
    output logic             done_o,
    output logic             error_o,
    output logic [idx_w-1:0] err_stage_o
);

    state_e           state;
    logic [idx_w-1:0] idx;
    logic             ack, wait_tc, ack_tc;

    assign ack = stage_ack_i[idx];

    bsg_reset_seq_counter #(.width_p(lg_wait_cycles_p)) wait_cnt (
        .clk_i  (clk_i),
        .clear_i(!reset_n_i || (state == eAck && ack)),
        .en_i   (state == eWait),
        .tc_o   (wait_tc)
    );

    // ack window restarts at every release so each stage gets the full timeout
    bsg_reset_seq_counter #(.width_p(lg_ack_timeout_p)) ack_cnt (
        .clk_i  (clk_i),
        .clear_i(!reset_n_i || (state == eWait && wait_tc)),
        .en_i   (state == eAck && !ack),
        .tc_o   (ack_tc)
    );

    always_ff @(posedge clk_i)
        if (!reset_n_i) begin
            state         <= eWait;
            idx           <= '0;
            stage_reset_o <= '1;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
            err_stage_o   <= '0;
        end else case (state)
            eWait:
                if (wait_tc) begin
                    stage_reset_o[idx] <= 1'b0;
                    state              <= eAck;
                end
            eAck:
                if (ack) begin
                    if (idx == idx_w'(els_p - 1)) begin
                        state  <= eDone;
                        done_o <= 1'b1;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= eWait;
                    end
                end else if (ack_tc) begin
                    state         <= eError;
                    error_o       <= 1'b1;
                    err_stage_o   <= idx;
                    stage_reset_o <= '1;
                end
            default: ;
        endcase

endmodule

// File: tb/tb_bsg_reset_release_sequencer.sv
// tb_bsg_reset_release_sequencer: directed checks of release timing, timeout, reset abort and stray acks
module tb_bsg_reset_release_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] ack = 3'b000;
    logic [2:0] stage_reset;
    logic       done, error;
    logic [1:0] err_stage;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    bsg_reset_release_sequencer dut (
        .clk_i        (clk),
        .reset_n_i    (reset_n),
        .stage_ack_i  (ack),
        .stage_reset_o(stage_reset),
        .done_o       (done),
        .error_o      (error),
        .err_stage_o  (err_stage)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] sr, input logic d, input logic e, input logic [1:0] es);
        chk({tag, ".stage_reset"}, 32'(stage_reset), 32'(sr));
        chk({tag, ".done"}, 32'(done), 32'(d));
        chk({tag, ".error"}, 32'(error), 32'(e));
        chk({tag, ".err_stage"}, 32'(err_stage), 32'(es));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        tick(1);
        reset_n = 1'b1;
    endtask

    initial begin
        ack = 3'b111;
        do_reset();
        chk_all("rst", 3'b111, 1'b0, 1'b0, 2'd0);
        tick(15);
        chk("t1.e15", 32'(stage_reset), 32'b111);
        tick(1);
        chk("t1.e16", 32'(stage_reset), 32'b110);
        tick(16);
        chk("t1.e32", 32'(stage_reset), 32'b110);
        tick(1);
        chk("t1.e33", 32'(stage_reset), 32'b100);
        tick(17);
        chk_all("t1.e50", 3'b000, 1'b0, 1'b0, 2'd0);
        tick(1);
        chk_all("t1.e51", 3'b000, 1'b1, 1'b0, 2'd0);
        ack = 3'b000;
        tick(10);
        chk_all("t1.hold", 3'b000, 1'b1, 1'b0, 2'd0);

        ack = 3'b101;
        do_reset();
        tick(33);
        chk("t2.e33", 32'(stage_reset), 32'b100);
        tick(7);
        chk_all("t2.e40", 3'b100, 1'b0, 1'b0, 2'd0);
        tick(1);
        chk_all("t2.e41", 3'b111, 1'b0, 1'b1, 2'd1);
        ack = 3'b111;
        tick(5);
        chk_all("t2.sticky", 3'b111, 1'b0, 1'b1, 2'd1);

        ack = 3'b000;
        do_reset();
        tick(23);
        chk("t3.e23", 32'(stage_reset), 32'b110);
        ack = 3'b001;
        tick(1);
        ack = 3'b000;
        chk_all("t3.e24", 3'b110, 1'b0, 1'b0, 2'd0);
        tick(15);
        chk("t3.e39", 32'(stage_reset), 32'b110);
        tick(1);
        chk("t3.e40", 32'(stage_reset), 32'b100);
        tick(8);
        chk_all("t3.e48", 3'b111, 1'b0, 1'b1, 2'd1);

        ack = 3'b111;
        do_reset();
        tick(19);
        chk("t4.e19", 32'(stage_reset), 32'b110);
        reset_n = 1'b0;
        tick(1);
        chk_all("t4.abort", 3'b111, 1'b0, 1'b0, 2'd0);
        reset_n = 1'b1;
        tick(15);
        chk("t4.r15", 32'(stage_reset), 32'b111);
        tick(1);
        chk("t4.r16", 32'(stage_reset), 32'b110);

        ack = 3'b110;
        do_reset();
        tick(23);
        chk_all("t5.e23", 3'b110, 1'b0, 1'b0, 2'd0);
        tick(1);
        chk_all("t5.e24", 3'b111, 1'b0, 1'b1, 2'd0);
        reset_n = 1'b0;
        tick(3);
        chk_all("t5.held", 3'b111, 1'b0, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
